// File: rtl/beacon_pkg.sv
// rtl/beacon_pkg.sv - shared beacon word codes, packet constants and field offsets
package beacon_pkg;

  localparam logic [1:0]  HEAD = 2'b01;
  localparam logic [1:0]  BODY = 2'b11;
  localparam logic [1:0]  TAIL = 2'b10;

  localparam logic [7:0]  PKT_UPDATE = 8'h02;
  localparam logic [7:0]  PKT_REPORT = 8'h01;

  localparam logic [15:0] BEACON_LEN      = 16'd64;
  localparam logic [15:0] ETHTYPE_DEFAULT = 16'h1662;

  localparam int WORD_W = 134;

  // Bit offsets inside a 134-bit bus word; shared with the LCM receiver and report path.
  localparam int WTYPE_LSB    = 132;
  localparam int INVB_LSB     = 128;
  localparam int MD_LMID_LSB  = 120;
  localparam int MD_TYPE_LSB  = 112;
  localparam int MD_LEN_LSB   = 96;
  localparam int MD_SEQ_LSB   = 64;
  localparam int ETH_DMAC_LSB = 80;
  localparam int ETH_SMAC_LSB = 32;
  localparam int ETH_TYPE_LSB = 16;
  localparam int UPD_DIR_BIT  = 127;
  localparam int UPD_TB_LSB   = 64;
  localparam int UPD_DMAC_LSB = 16;
  localparam int UPD_TSP_LSB  = 96;
  localparam int UPD_TS_LSB   = 48;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    S_W0     = 3'd2,
    S_W1     = 3'd3,
    S_W2     = 3'd4,
    S_W3     = 3'd5
  } tx_state_e;

  function automatic logic is_word_state(tx_state_e s);
    return (s == S_W0) || (s == S_W1) || (s == S_W2) || (s == S_W3);
  endfunction

endpackage

// File: rtl/beacon_word_mux.sv
// rtl/beacon_word_mux.sv - maps the transmit state and latched fields to one bus word
module beacon_word_mux
  import beacon_pkg::*;
#(
  parameter logic [7:0]  LMID    = 8'd1,
  parameter logic [15:0] ETHTYPE = ETHTYPE_DEFAULT
) (
  input  logic [2:0]   state_i,
  input  logic         direction_i,
  input  logic [31:0]  token_bucket_i,
  input  logic [47:0]  direct_mac_i,
  input  logic [31:0]  time_slot_i,
  input  logic [47:0]  dmac_i,
  input  logic [47:0]  smac_i,
  input  logic [31:0]  seq_i,
  input  logic [47:0]  ts_i,
  output logic [133:0] word_o
);

  logic [133:0] word;

  always_comb begin
    word = '0;
    case (tx_state_e'(state_i))
      S_W0: begin
        word[WTYPE_LSB +: 2]    = HEAD;
        word[MD_LMID_LSB +: 8]  = LMID;
        word[MD_TYPE_LSB +: 8]  = PKT_UPDATE;
        word[MD_LEN_LSB +: 16]  = BEACON_LEN;
        word[MD_SEQ_LSB +: 32]  = seq_i;
      end
      S_W1: begin
        word[WTYPE_LSB +: 2]    = BODY;
        word[ETH_DMAC_LSB +: 48] = dmac_i;
        word[ETH_SMAC_LSB +: 48] = smac_i;
        word[ETH_TYPE_LSB +: 16] = ETHTYPE;
      end
      S_W2: begin
        word[WTYPE_LSB +: 2]     = BODY;
        word[UPD_DIR_BIT]        = direction_i;
        word[UPD_TB_LSB +: 32]   = token_bucket_i;
        word[UPD_DMAC_LSB +: 48] = direct_mac_i;
      end
      S_W3: begin
        word[WTYPE_LSB +: 2]    = TAIL;
        word[UPD_TSP_LSB +: 32] = time_slot_i;
        word[UPD_TS_LSB +: 48]  = ts_i;
      end
      default: ;
    endcase
  end

  assign word_o = word;

endmodule

// File: rtl/beacon_update_tx.sv
// rtl/beacon_update_tx.sv - formats controller beacon updates into 4-word packets for the LCM
module beacon_update_tx
  import beacon_pkg::*;
#(
  parameter logic [7:0]  LMID    = 8'd1,
  parameter logic [15:0] ETHTYPE = ETHTYPE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         req_direction,
  input  logic [31:0]  req_token_bucket_para,
  input  logic [47:0]  req_direct_mac_addr,
  input  logic [31:0]  req_time_slot_period,
  input  logic [47:0]  req_dmac,
  input  logic [47:0]  local_mac,
  input  logic [47:0]  precision_time,
  input  logic         in_ready,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  output logic         busy,
  output logic [31:0]  tx_cnt,
  output logic [31:0]  drop_cnt
);

  tx_state_e    state_q, state_d;
  logic         latch_en, drop;
  logic         dir_q;
  logic [31:0]  tb_q, tsp_q, seq_q, tx_cnt_q, drop_cnt_q;
  logic [47:0]  dmm_q, dmac_q, smac_q, ts_q;
  logic [133:0] word_d, out_data_q;
  logic         out_wr_q, valid_q, busy_q;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          state_d  = WAIT_RDY;
        end
      end
      WAIT_RDY: if (in_ready) state_d = S_W0;
      S_W0:     state_d = S_W1;
      S_W1:     state_d = S_W2;
      S_W2:     state_d = S_W3;
      S_W3:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A request arriving on the S_W3 edge is dropped even though the FSM goes idle.
    if (req && (state_q != IDLE)) drop = 1'b1;
  end

  beacon_word_mux #(
    .LMID    (LMID),
    .ETHTYPE (ETHTYPE)
  ) u_word_mux (
    .state_i        (state_d),
    .direction_i    (dir_q),
    .token_bucket_i (tb_q),
    .direct_mac_i   (dmm_q),
    .time_slot_i    (tsp_q),
    .dmac_i         (dmac_q),
    .smac_i         (smac_q),
    .seq_i          (seq_q),
    .ts_i           (ts_q),
    .word_o         (word_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      tb_q       <= '0;
      dmm_q      <= '0;
      tsp_q      <= '0;
      dmac_q     <= '0;
      smac_q     <= '0;
      ts_q       <= '0;
      seq_q      <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        dir_q  <= req_direction;
        tb_q   <= req_token_bucket_para;
        dmm_q  <= req_direct_mac_addr;
        tsp_q  <= req_time_slot_period;
        dmac_q <= req_dmac;
        smac_q <= local_mac;
      end
      // Timestamp is captured on the edge that emits the head word.
      if (state_d == S_W0) ts_q <= precision_time;
      if (state_q == S_W3) begin
        seq_q    <= seq_q + 32'd1;
        tx_cnt_q <= tx_cnt_q + 32'd1;
      end
      if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
      out_data_q <= word_d;
      out_wr_q   <= is_word_state(state_d);
      valid_q    <= (state_d == S_W3);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign out_data          = out_data_q;
  assign out_data_wr       = out_wr_q;
  assign out_data_valid    = valid_q;
  assign out_data_valid_wr = valid_q;
  assign busy              = busy_q;
  assign tx_cnt            = tx_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_beacon_update_tx.sv
// tb/tb_beacon_update_tx.sv - directed self-checking bench for beacon_update_tx
module tb_beacon_update_tx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         req_direction = 1'b0;
  logic [31:0]  req_token_bucket_para = '0;
  logic [47:0]  req_direct_mac_addr = '0;
  logic [31:0]  req_time_slot_period = '0;
  logic [47:0]  req_dmac = '0;
  logic [47:0]  local_mac = 48'h02AA_BBCC_DDEE;
  logic [47:0]  precision_time = 48'h0000_0100_0000;
  logic         in_ready = 1'b0;
  logic [133:0] out_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr, busy;
  logic [31:0]  tx_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic ramp_en = 1'b0;

  beacon_update_tx dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req                   (req),
    .req_direction         (req_direction),
    .req_token_bucket_para (req_token_bucket_para),
    .req_direct_mac_addr   (req_direct_mac_addr),
    .req_time_slot_period  (req_time_slot_period),
    .req_dmac              (req_dmac),
    .local_mac             (local_mac),
    .precision_time        (precision_time),
    .in_ready              (in_ready),
    .out_data              (out_data),
    .out_data_wr           (out_data_wr),
    .out_data_valid        (out_data_valid),
    .out_data_valid_wr     (out_data_valid_wr),
    .busy                  (busy),
    .tx_cnt                (tx_cnt),
    .drop_cnt              (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (ramp_en) precision_time <= precision_time + 48'd8;
  end

  function automatic logic [133:0] exp_word(input int idx, input logic dir, input logic [31:0] tbp,
                                            input logic [47:0] dmm, input logic [31:0] tsp,
                                            input logic [47:0] dmac, input logic [31:0] seq,
                                            input logic [47:0] ts);
    case (idx)
      0:       return {2'b01, 4'h0, 8'h01, 8'h02, 16'd64, seq, 64'h0};
      1:       return {2'b11, 4'h0, dmac, local_mac, 16'h1662, 16'h0};
      2:       return {2'b11, 4'h0, dir, 31'h0, tbp, dmm, 16'h0};
      default: return {2'b10, 4'h0, tsp, ts, 48'h0};
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    in_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req(input logic d, input logic [31:0] t, input logic [47:0] m,
                           input logic [31:0] p, input logic [47:0] dm);
    req = 1'b1;
    req_direction = d;
    req_token_bucket_para = t;
    req_direct_mac_addr = m;
    req_time_slot_period = p;
    req_dmac = dm;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // Waits for a head word, then captures four consecutive words; optional req/in_ready pokes mid-packet.
  task automatic get_pkt(input int req_at_word, input int drop_rdy_at, output logic [3:0][133:0] w,
                         output int lat, output bit ok, output logic [3:0] vm, output logic [3:0] vwm,
                         output logic [47:0] pth, output int hc);
    int n;
    bit gap;
    n = 0; lat = 0; gap = 1'b0; w = '0; vm = '0; vwm = '0; pth = '0; hc = 0;
    while (lat == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_data_wr === 1'b1) lat = n;
    end
    if (lat == 0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (out_data_wr !== 1'b1) gap = 1'b1;
      end
      w[i] = out_data;
      vm[i] = out_data_valid;
      vwm[i] = out_data_valid_wr;
      if (i == 0) begin
        pth = precision_time;
        hc = cyc;
      end
      if (req_at_word >= 0) begin
        if (i == req_at_word) req = 1'b1;
        else if (i > req_at_word) req = 1'b0;
      end
      if (i == drop_rdy_at) in_ready = 1'b0;
    end
    ok = !gap;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_data !== 134'h0 || out_data_wr !== 1'b0 || out_data_valid !== 1'b0 || out_data_valid_wr !== 1'b0) begin
      errors++; $display("FAIL reset_outputs data=%h wr=%b v=%b vwr=%b exp all 0", out_data, out_data_wr, out_data_valid, out_data_valid_wr);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (tx_cnt !== 32'h0 || drop_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_counters tx=%h drop=%h exp 0", tx_cnt, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_data_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release wr=%b busy=%b exp 0/0", out_data_wr, busy);
    end
  endtask

  task automatic test_basic();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    do_reset();
    in_ready = 1'b1;
    pulse_req(1'b1, 32'h0010_0200, 48'h0011_2233_4455, 32'h7A12, 48'h0A0B_0C0D_0E0F);
    get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_contig got=gap_or_timeout exp=4 contiguous words"); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++;
    if (w[0][133:132] !== 2'b01) begin errors++; $display("FAIL basic_head_type got=%b exp=01", w[0][133:132]); end
    checks++;
    if (w[3][133:132] !== 2'b10) begin errors++; $display("FAIL basic_tail_type got=%b exp=10", w[3][133:132]); end
    checks++;
    if (w[3][127:96] !== 32'h7A12) begin errors++; $display("FAIL basic_tsp got=%h exp=00007a12", w[3][127:96]); end
    for (int i = 0; i < 4; i++) begin
      logic [133:0] e;
      e = exp_word(i, 1'b1, 32'h0010_0200, 48'h0011_2233_4455, 32'h7A12, 48'h0A0B_0C0D_0E0F, 32'h0, precision_time);
      checks++;
      if (w[i] !== e) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, w[i], e); end
    end
    checks++;
    if (vm !== 4'b1000 || vwm !== 4'b1000) begin
      errors++; $display("FAIL basic_valid got v=%b vwr=%b exp 1000/1000", vm, vwm);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_data_wr !== 1'b0) begin errors++; $display("FAIL basic_end busy=%b wr=%b exp 0/0", busy, out_data_wr); end
    checks++;
    if (tx_cnt !== 32'd1 || drop_cnt !== 32'd0) begin errors++; $display("FAIL basic_counts tx=%0d drop=%0d exp 1/0", tx_cnt, drop_cnt); end
  endtask

  task automatic test_backpressure();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    bit any_wr, all_busy;
    do_reset();
    pulse_req(1'b0, 32'h1234_5678, 48'hA1A2_A3A4_A5A6, 32'h0000_1000, 48'h0600_0000_0001);
    any_wr = 1'b0; all_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_data_wr !== 1'b0) any_wr = 1'b1;
      if (busy !== 1'b1) all_busy = 1'b0;
    end
    checks++;
    if (any_wr) begin errors++; $display("FAIL bp_no_wr got=wr_seen exp=no wr while in_ready=0"); end
    checks++;
    if (!all_busy) begin errors++; $display("FAIL bp_busy got=busy_low exp=busy 1 while waiting"); end
    in_ready = 1'b1;
    get_pkt(-1, 1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL bp_head_latency got=%0d exp=1", lat); end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_no_stall got=gap_or_timeout exp=4 contiguous words"); end
    for (int i = 0; i < 4; i++) begin
      logic [133:0] e;
      e = exp_word(i, 1'b0, 32'h1234_5678, 48'hA1A2_A3A4_A5A6, 32'h0000_1000, 48'h0600_0000_0001, 32'h0, precision_time);
      checks++;
      if (w[i] !== e) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, w[i], e); end
    end
  endtask

  task automatic test_busy_reject();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    bit any_wr;
    do_reset();
    in_ready = 1'b1;
    pulse_req(1'b1, 32'hCAFE_0001, 48'h1111_2222_3333, 32'h0000_0400, 48'h0C00_0000_00AA);
    req_direction = 1'b0;
    req_token_bucket_para = 32'hDEAD_BEEF;
    req_direct_mac_addr = 48'h9999_8888_7777;
    req_time_slot_period = 32'h5555_5555;
    req_dmac = 48'h0D00_0000_00BB;
    get_pkt(2, -1, w, lat, ok, vm, vwm, pth, hc);
    for (int i = 0; i < 4; i++) begin
      logic [133:0] e;
      e = exp_word(i, 1'b1, 32'hCAFE_0001, 48'h1111_2222_3333, 32'h0000_0400, 48'h0C00_0000_00AA, 32'h0, precision_time);
      checks++;
      if (w[i] !== e) begin errors++; $display("FAIL rej_word%0d got=%h exp=%h", i, w[i], e); end
    end
    @(negedge clk);
    checks++;
    if (drop_cnt !== 32'd1 || tx_cnt !== 32'd1) begin errors++; $display("FAIL rej_counts drop=%0d tx=%0d exp 1/1", drop_cnt, tx_cnt); end
    any_wr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_data_wr !== 1'b0 || busy !== 1'b0) any_wr = 1'b1;
    end
    checks++;
    if (any_wr) begin errors++; $display("FAIL rej_no_second got=activity exp=idle after rejected req"); end
  endtask

  task automatic test_edge_drop();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    bit any_wr;
    do_reset();
    in_ready = 1'b1;
    pulse_req(1'b0, 32'h0000_0042, 48'h0000_0000_0042, 32'h0000_0042, 48'h0E00_0000_0042);
    get_pkt(3, -1, w, lat, ok, vm, vwm, pth, hc);
    @(posedge clk);
    #1 req = 1'b0;
    any_wr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_data_wr !== 1'b0 || busy !== 1'b0) any_wr = 1'b1;
    end
    checks++;
    if (any_wr) begin errors++; $display("FAIL edge_drop_idle got=activity exp=req on S_W3 edge ignored"); end
    checks++;
    if (drop_cnt !== 32'd1 || tx_cnt !== 32'd1) begin errors++; $display("FAIL edge_drop_counts drop=%0d tx=%0d exp 1/1", drop_cnt, tx_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0][133:0] w; int lat, hc, prev_hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    do_reset();
    in_ready = 1'b1;
    prev_hc = 0;
    for (int k = 0; k < 3; k++) begin
      logic [133:0] e;
      pulse_req(k[0], 32'h0000_0100 + k, 48'h0000_0000_00B0 + k, 32'h0000_0200 + k, 48'h0F00_0000_0000 + k);
      get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
      checks++;
      if (w[0][95:64] !== k[31:0]) begin errors++; $display("FAIL b2b_seq%0d got=%h exp=%h", k, w[0][95:64], k); end
      e = exp_word(3, k[0], 32'h0000_0100 + k, 48'h0000_0000_00B0 + k, 32'h0000_0200 + k, 48'h0F00_0000_0000 + k, k[31:0], precision_time);
      checks++;
      if (w[3] !== e || !ok) begin errors++; $display("FAIL b2b_tail%0d got=%h exp=%h ok=%b", k, w[3], e, ok); end
      if (k > 0) begin
        checks++;
        if (hc - prev_hc != 6) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=6", k, hc - prev_hc); end
      end
      prev_hc = hc;
      @(negedge clk);
    end
    checks++;
    if (tx_cnt !== 32'd3) begin errors++; $display("FAIL b2b_tx_cnt got=%0d exp=3", tx_cnt); end
    force dut.seq_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.seq_q;
    pulse_req(1'b1, 32'h0000_0AAA, 48'h0000_0000_0AAA, 32'h0000_0AAA, 48'h0F00_0000_0AAA);
    get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (w[0][95:64] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_seq_max got=%h exp=ffffffff", w[0][95:64]); end
    @(negedge clk);
    pulse_req(1'b0, 32'h0000_0BBB, 48'h0000_0000_0BBB, 32'h0000_0BBB, 48'h0F00_0000_0BBB);
    get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (w[0] !== exp_word(0, 1'b0, 32'h0, 48'h0, 32'h0, 48'h0, 32'h0, 48'h0)) begin
      errors++; $display("FAIL wrap_seq_zero got=%h exp seq=00000000", w[0]);
    end
  endtask

  task automatic test_timestamp();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth, pt_req;
    do_reset();
    ramp_en = 1'b1;
    @(negedge clk);
    pt_req = precision_time;
    pulse_req(1'b1, 32'h0000_7777, 48'h0000_0000_7777, 32'h0000_1111, 48'h0B00_0000_0001);
    repeat (3) @(negedge clk);
    in_ready = 1'b1;
    get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (w[3][95:48] !== pth - 48'd8) begin errors++; $display("FAIL ts_at_head got=%h exp=%h", w[3][95:48], pth - 48'd8); end
    checks++;
    if (w[3][95:48] === pt_req) begin errors++; $display("FAIL ts_not_req got=%h exp=not %h", w[3][95:48], pt_req); end
    checks++;
    if (w[3] !== exp_word(3, 1'b1, 32'h0, 48'h0, 32'h0000_1111, 48'h0, 32'h0, pth - 48'd8)) begin
      errors++; $display("FAIL ts_tail_word got=%h", w[3]);
    end
    ramp_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0][133:0] w; int lat, hc; bit ok; logic [3:0] vm, vwm; logic [47:0] pth;
    bit any_wr;
    do_reset();
    in_ready = 1'b1;
    pulse_req(1'b1, 32'h0000_0321, 48'h0000_0000_0321, 32'h0000_0321, 48'h0A00_0000_0321);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_data_wr !== 1'b1 || out_data[133:132] !== 2'b01) begin
      errors++; $display("FAIL rstmid_head got wr=%b type=%b exp 1/01", out_data_wr, out_data[133:132]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_data !== 134'h0 || out_data_wr !== 1'b0 || out_data_valid !== 1'b0 || out_data_valid_wr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear data=%h wr=%b v=%b vwr=%b busy=%b exp all 0", out_data, out_data_wr, out_data_valid, out_data_valid_wr, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    any_wr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_data_wr !== 1'b0 || busy !== 1'b0) any_wr = 1'b1;
    end
    checks++;
    if (any_wr) begin errors++; $display("FAIL rstmid_idle got=activity exp=idle after reset"); end
    checks++;
    if (tx_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_tx_cnt got=%0d exp=0", tx_cnt); end
    pulse_req(1'b0, 32'h0000_0654, 48'h0000_0000_0654, 32'h0000_0654, 48'h0A00_0000_0654);
    get_pkt(-1, -1, w, lat, ok, vm, vwm, pth, hc);
    checks++;
    if (w[0][95:64] !== 32'h0 || !ok) begin errors++; $display("FAIL rstmid_seq got=%h ok=%b exp=00000000", w[0][95:64], ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_reject();
    test_edge_drop();
    test_back_to_back();
    test_timestamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
